// File: rtl/adder_tree_pkg.sv
// Shared constants and FSM encoding for the adder-tree input loader.
package adder_tree_pkg;
    localparam int DATA_W       = 8;
    localparam int LANES        = 8;
    localparam int TREE_LATENCY = 3;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;
endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth register pipeline that carries {valid, len} alongside the adder tree.
module valid_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];
endmodule

// File: rtl/adder_input_loader.sv
// Packs a sample stream into 8-lane frames for the adder tree and tracks
// when each frame's sum emerges from the tree.
module adder_input_loader #(
    parameter int DATA_W       = adder_tree_pkg::DATA_W,
    parameter int LANES        = adder_tree_pkg::LANES,
    parameter int TREE_LATENCY = adder_tree_pkg::TREE_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] in0,
    output logic [DATA_W-1:0] in1,
    output logic [DATA_W-1:0] in2,
    output logic [DATA_W-1:0] in3,
    output logic [DATA_W-1:0] in4,
    output logic [DATA_W-1:0] in5,
    output logic [DATA_W-1:0] in6,
    output logic [DATA_W-1:0] in7,
    output logic              launch,
    output logic              sum_valid,
    output logic [3:0]        sum_len
);
    import adder_tree_pkg::*;

    localparam int IDX_W = $clog2(LANES);

    state_t                       state, state_nx;
    logic [IDX_W-1:0]             idx, idx_nx;
    logic [LANES-1:0][DATA_W-1:0] collect, frame_q, frame_nx;
    logic                         accept, closing, launch_q;
    logic [3:0]                   len_q;
    logic [4:0]                   dl_d, dl_q;

    always_comb begin
        accept   = s_valid && s_ready;
        closing  = accept && (s_last || idx == IDX_W'(LANES-1));
        state_nx = state;
        idx_nx   = idx;
        // Lanes past idx are already zero because collect clears on every close.
        frame_nx      = collect;
        frame_nx[idx] = s_data;
        if (accept) begin
            if (closing) begin
                state_nx = IDLE;
                idx_nx   = '0;
            end else begin
                state_nx = FILL;
                idx_nx   = idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_ready  <= 1'b0;
            state    <= IDLE;
            idx      <= '0;
            collect  <= '0;
            frame_q  <= '0;
            launch_q <= 1'b0;
            len_q    <= '0;
        end else begin
            s_ready  <= 1'b1;
            state    <= state_nx;
            idx      <= idx_nx;
            launch_q <= closing;
            if (closing) begin
                frame_q <= frame_nx;
                collect <= '0;
                len_q   <= 4'(idx) + 4'd1;
            end else if (accept) begin
                collect[idx] <= s_data;
            end
        end
    end

    assign dl_d = {launch_q, launch_q ? len_q : 4'd0};

    valid_delay_line #(
        .DEPTH (TREE_LATENCY),
        .WIDTH (5)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .d   (dl_d),
        .q   (dl_q)
    );

    assign launch    = launch_q;
    assign sum_valid = dl_q[4];
    assign sum_len   = dl_q[3:0];

    assign in0 = frame_q[0];
    assign in1 = frame_q[1];
    assign in2 = frame_q[2];
    assign in3 = frame_q[3];
    assign in4 = frame_q[4];
    assign in5 = frame_q[5];
    assign in6 = frame_q[6];
    assign in7 = frame_q[7];
endmodule

// File: tb/tb_adder_input_loader.sv
// Directed bench for adder_input_loader: table of frames plus reset/back-to-back sequences.
module tb_adder_input_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid, s_last, s_ready;
    logic [7:0] in0, in1, in2, in3, in4, in5, in6, in7;
    logic       launch, sum_valid;
    logic [3:0] sum_len;

    int checks = 0;
    int errors = 0;

    adder_input_loader dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .in5(in5), .in6(in6), .in7(in7), .launch(launch), .sum_valid(sum_valid),
        .sum_len(sum_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               n;
        logic             last;
        logic [7:0][7:0]  d;
        logic [7:0][7:0]  lanes;
        int               len;
        int               sum;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0][7:0] lanes_now();
        return {in7, in6, in5, in4, in3, in2, in1, in0};
    endfunction

    function automatic int tree_sum();
        return int'(in0) + int'(in1) + int'(in2) + int'(in3) +
               int'(in4) + int'(in5) + int'(in6) + int'(in7);
    endfunction

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            @(negedge clk);
            if (i > 0) chk("launch_early", 64'(launch), 64'd0);
            s_valid = 1'b1;
            s_data  = v.d[i];
            s_last  = v.last && (i == v.n - 1);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("launch", 64'(launch), 64'd1);
        chk("lanes", 64'(lanes_now()), 64'(v.lanes));
        chk("tree_sum", 64'(tree_sum()), 64'(v.sum));
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("launch_single", 64'(launch), 64'd0);
            chk("lanes_hold", 64'(lanes_now()), 64'(v.lanes));
            chk("sum_valid_t", 64'(sum_valid), 64'(k == 3));
        end
        chk("sum_len", 64'(sum_len), 64'(v.len));
        @(negedge clk);
        chk("sum_valid_end", 64'(sum_valid), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        chk({tag, "_launch"}, 64'(launch), 64'd0);
        chk({tag, "_sum_valid"}, 64'(sum_valid), 64'd0);
        chk({tag, "_sum_len"}, 64'(sum_len), 64'd0);
        chk({tag, "_lanes"}, 64'(lanes_now()), 64'd0);
    endtask

    initial begin
        int n_launch, n_sv;
        logic [7:0][7:0] l1, l2;

        for (int i = 0; i < 8; i++) begin
            vecs[0].d[i] = 8'(i + 1);
            vecs[3].d[i] = 8'(i + 1);
            vecs[4].d[i] = 8'((i + 1) * 16);
        end
        vecs[0].n = 8; vecs[0].last = 1'b0; vecs[0].lanes = vecs[0].d; vecs[0].len = 8; vecs[0].sum = 36;
        vecs[1].d = '0; vecs[1].d[0] = 8'd5; vecs[1].d[1] = 8'd6; vecs[1].d[2] = 8'd7;
        vecs[1].n = 3; vecs[1].last = 1'b1; vecs[1].lanes = vecs[1].d; vecs[1].len = 3; vecs[1].sum = 18;
        vecs[2].d = '0; vecs[2].d[0] = 8'h2A;
        vecs[2].n = 1; vecs[2].last = 1'b1; vecs[2].lanes = vecs[2].d; vecs[2].len = 1; vecs[2].sum = 42;
        vecs[3].n = 8; vecs[3].last = 1'b1; vecs[3].lanes = vecs[3].d; vecs[3].len = 8; vecs[3].sum = 36;
        vecs[4].n = 8; vecs[4].last = 1'b0; vecs[4].lanes = vecs[4].d; vecs[4].len = 8; vecs[4].sum = 576;

        rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        @(negedge clk); @(negedge clk);
        chk_reset_outputs("rst0");
        rst = 1'b1;
        @(negedge clk);
        chk("s_ready_rise", 64'(s_ready), 64'd1);

        for (int v = 0; v < 5; v++) run_vec(vecs[v]);

        // s_last without s_valid in IDLE must not open or close a frame
        s_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle_last_launch", 64'(launch), 64'd0);
            chk("idle_last_sv", 64'(sum_valid), 64'd0);
        end
        s_last = 1'b0;

        // back-to-back frames: 8x 0xFF then 8x 0x01 with no gap
        n_launch = 0; n_sv = 0; l1 = '0; l2 = '0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (launch) begin
                n_launch++;
                chk("b2b_launch_cyc", 64'(c), 64'(n_launch == 1 ? 8 : 16));
                if (n_launch == 1) l1 = lanes_now(); else l2 = lanes_now();
            end
            if (sum_valid) begin
                n_sv++;
                chk("b2b_sv_cyc", 64'(c), 64'(n_sv == 1 ? 11 : 19));
                chk("b2b_sum_len", 64'(sum_len), 64'd8);
            end
            s_valid = (c < 16);
            s_data  = (c < 8) ? 8'hFF : 8'h01;
        end
        chk("b2b_n_launch", 64'(n_launch), 64'd2);
        chk("b2b_n_sv", 64'(n_sv), 64'd2);
        chk("b2b_lanes1", 64'(l1), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("b2b_lanes2", 64'(l2), 64'h0101_0101_0101_0101);

        // reset after 4 samples discards the partial frame
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 8'(8'h90 + i);
        end
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        run_vec(vecs[0]);

        // reset one cycle after a launch cancels the in-flight sum
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 8'(i + 1);
        end
        @(negedge clk);
        s_valid = 1'b0;
        chk("pre_rst_launch", 64'(launch), 64'd1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst_inflight");
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("no_sv_after_rst", 64'(sum_valid), 64'd0);
            chk("no_launch_after_rst", 64'(launch), 64'd0);
        end
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
